// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types and helpers for the round-robin
// AXI-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-entry registered AXI-Stream slice that
// carries tdata/tlast/tid at one beat per cycle.
module axis_reg_slice
    import axis_arb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_ID_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [P_DATA_WIDTH-1:0] in_data_i,
    input  logic                    in_last_i,
    input  logic [P_ID_WIDTH-1:0]   in_id_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [P_DATA_WIDTH-1:0] out_data_o,
    output logic                    out_last_o,
    output logic [P_ID_WIDTH-1:0]   out_id_o
);

    logic                    valid_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic                    last_q;
    logic [P_ID_WIDTH-1:0]   id_q;

    // Refill in the same cycle the held beat drains.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            last_q  <= in_last_i;
            id_q    <= in_id_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_id_o    = id_q;

endmodule

// File: rtl/axis_rr_arb.sv
// axis_rr_arb: packet-granular round-robin merge of N AXI-Stream
// requesters into one registered output stream.
module axis_rr_arb
    import axis_arb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_NUM_INPUTS = 4,
    parameter int P_MAX_BEATS  = 256,
    localparam int IW = idx_width(P_NUM_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [P_NUM_INPUTS-1:0]              s_axis_tvalid,
    output logic [P_NUM_INPUTS-1:0]              s_axis_tready,
    input  logic [P_NUM_INPUTS*P_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [P_NUM_INPUTS-1:0]              s_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [P_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                                 m_axis_tlast,
    output logic [IW-1:0]                        m_axis_tid,
    output logic                                 trunc_err
);

    localparam int CW = $clog2(P_MAX_BEATS + 1);

    arb_state_e              state_q;
    logic [IW-1:0]           grant_q;
    logic [IW-1:0]           last_q;
    logic [CW-1:0]           cnt_q;
    logic                    trunc_q;

    logic                    slice_rdy;
    logic                    acc;
    logic                    beat_last;
    logic                    trunc;
    logic [P_DATA_WIDTH-1:0] beat_data;

    function automatic logic [IW-1:0] rr_pick(
        input logic [P_NUM_INPUTS-1:0] req,
        input logic [IW-1:0]           last
    );
        logic [IW-1:0] pick;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= P_NUM_INPUTS; i++) begin
            int j;
            j = (int'(last) + i) % P_NUM_INPUTS;
            if (!found && req[j]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign beat_data = s_axis_tdata[int'(grant_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
    assign beat_last = s_axis_tlast[grant_q];
    assign acc       = (state_q == S_GRANT) && slice_rdy
                       && s_axis_tvalid[grant_q];
    // Limit reached on a beat that does not end the packet.
    assign trunc     = !beat_last && (cnt_q == CW'(P_MAX_BEATS - 1));

    always_comb begin
        s_axis_tready = '0;
        if (state_q == S_GRANT && slice_rdy)
            s_axis_tready[grant_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(P_NUM_INPUTS - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= acc && trunc;
            case (state_q)
                S_IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q <= rr_pick(s_axis_tvalid, last_q);
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (acc) begin
                        if (beat_last || trunc) begin
                            state_q <= S_IDLE;
                            last_q  <= grant_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .P_ID_WIDTH  (IW)
    ) u_slice (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (acc),
        .in_ready_o (slice_rdy),
        .in_data_i  (beat_data),
        .in_last_i  (beat_last | trunc),
        .in_id_i    (grant_q),
        .out_valid_o(m_axis_tvalid),
        .out_ready_i(m_axis_tready),
        .out_data_o (m_axis_tdata),
        .out_last_o (m_axis_tlast),
        .out_id_o   (m_axis_tid)
    );

    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// tb_axis_rr_arb: table, directed and randomized checks of the
// round-robin AXI-Stream arbiter against a packet-level model.
module tb_axis_rr_arb;

    localparam int NI = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0]    s_tvalid, s_tready, s_tlast;
    logic [NI*DW-1:0] s_tdata;
    logic             m_tvalid, m_tready, m_tlast, trunc;
    logic [DW-1:0]    m_tdata;
    logic [IW-1:0]    m_tid;

    logic [NI-1:0]    s2_tvalid, s2_tready, s2_tlast;
    logic [NI*DW-1:0] s2_tdata;
    logic             m2_tvalid, m2_tready, m2_tlast, trunc2;
    logic [DW-1:0]    m2_tdata;
    logic [IW-1:0]    m2_tid;

    axis_rr_arb #(.P_DATA_WIDTH(DW), .P_NUM_INPUTS(NI), .P_MAX_BEATS(256)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .trunc_err(trunc)
    );

    axis_rr_arb #(.P_DATA_WIDTH(DW), .P_NUM_INPUTS(NI), .P_MAX_BEATS(4)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
        .s_axis_tdata(s2_tdata), .s_axis_tlast(s2_tlast),
        .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
        .m_axis_tdata(m2_tdata), .m_axis_tlast(m2_tlast),
        .m_axis_tid(m2_tid), .trunc_err(trunc2)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: requester queues, one-deep expected output
    // and packet-level arbitration bookkeeping.
    typedef logic [DW:0] beat_t;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            id;
    } obeat_t;

    beat_t         q[NI][$];
    bit            acc[NI];
    obeat_t        exp_out[$];
    bit            busy;
    int            grant, last_g, cnt;
    bit            exp_tr;
    int            gap;
    logic [DW-1:0] log_d[$];
    int            log_id[$];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            q[i].delete();
            acc[i] = 0;
        end
        exp_out.delete();
        log_d.delete();
        log_id.delete();
        busy = 0; grant = 0; last_g = NI - 1; cnt = 0; exp_tr = 0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    endtask

    task automatic add_pkt(input int i, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++)
            q[i].push_back({(b == len - 1), base + DW'(b)});
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) begin
                s_tvalid[i] = 1'b0;
                acc[i] = 0;
            end
            if (q[i].size() == 0) begin
                s_tvalid[i] = 1'b0;
            end else begin
                if (!s_tvalid[i])
                    s_tvalid[i] = (int'($urandom_range(99)) >= gap);
                {s_tlast[i], s_tdata[i*DW +: DW]} = q[i][0];
            end
        end
    endtask

    task automatic pre(input logic rdy);
        m_tready = rdy;
        drive();
        #1;
    endtask

    task automatic model_step();
        logic [NI-1:0] erdy;
        bit            can, tr, found;
        beat_t         b;
        if (m_tvalid && m_tready) begin
            log_d.push_back(m_tdata);
            log_id.push_back(int'(m_tid));
        end
        chk("m_tvalid", m_tvalid, exp_out.size() != 0);
        if (exp_out.size() != 0) begin
            chk("m_tdata", m_tdata, exp_out[0].d);
            chk("m_tlast", m_tlast, exp_out[0].l);
            chk("m_tid", m_tid, exp_out[0].id);
        end
        chk("trunc_err", trunc, exp_tr);
        can = (exp_out.size() == 0) || m_tready;
        erdy = '0;
        if (busy && can) erdy[grant] = 1'b1;
        chk("s_tready", s_tready, erdy);
        exp_tr = 0;
        if (exp_out.size() != 0 && m_tready) void'(exp_out.pop_front());
        if (!busy) begin
            found = 0;
            for (int k = 1; k <= NI; k++) begin
                int j;
                j = (last_g + k) % NI;
                if (!found && s_tvalid[j]) begin
                    grant = j;
                    found = 1;
                end
            end
            if (found) begin
                busy = 1;
                cnt = 0;
            end
        end else if (can && s_tvalid[grant]) begin
            b = q[grant].pop_front();
            cnt++;
            tr = !b[DW] && (cnt == 256);
            exp_out.push_back('{d: b[DW-1:0], l: b[DW] | tr, id: grant});
            acc[grant] = 1;
            if (b[DW] || tr) begin
                busy = 0;
                last_g = grant;
                exp_tr = tr;
            end
        end
    endtask

    task automatic post();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_tready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tid", m_tid, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_s_tready", s_tready, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rdy;
        logic [NI-1:0] srdy;
        logic          v;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          l;
    } vec_t;

    vec_t          tbl[10];
    int            b2, tcnt, n;
    logic [DW-1:0] tdat;
    logic [DW-1:0] d2[$];
    logic          l2[$];
    logic          l2_exp[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        gap = 0;
        m_tready = 1'b1;
        s2_tvalid = '0; s2_tdata = '0; s2_tlast = '0; m2_tready = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_m2_tvalid", m2_tvalid, 0);
        chk("rst_s2_tready", s2_tready, 0);

        // Two 3-beat packets, inputs 0 and 2, sink always ready.
        tbl[0] = '{1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'h1, 1'b0, 16'h0000, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 4'h1, 1'b1, 16'h0001, 2'd0, 1'b0};
        tbl[3] = '{1'b1, 4'h1, 1'b1, 16'h0002, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 4'h0, 1'b1, 16'h0003, 2'd0, 1'b1};
        tbl[5] = '{1'b1, 4'h4, 1'b0, 16'h0000, 2'd0, 1'b0};
        tbl[6] = '{1'b1, 4'h4, 1'b1, 16'h0201, 2'd2, 1'b0};
        tbl[7] = '{1'b1, 4'h4, 1'b1, 16'h0202, 2'd2, 1'b0};
        tbl[8] = '{1'b1, 4'h0, 1'b1, 16'h0203, 2'd2, 1'b1};
        tbl[9] = '{1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b0};
        add_pkt(0, 3, 16'h0001);
        add_pkt(2, 3, 16'h0201);
        for (int c = 0; c < 10; c++) begin
            pre(tbl[c].rdy);
            chk($sformatf("tbl%0d_srdy", c), s_tready, tbl[c].srdy);
            chk($sformatf("tbl%0d_mvalid", c), m_tvalid, tbl[c].v);
            if (tbl[c].v) begin
                chk($sformatf("tbl%0d_data", c), m_tdata, tbl[c].d);
                chk($sformatf("tbl%0d_tid", c), m_tid, tbl[c].id);
                chk($sformatf("tbl%0d_last", c), m_tlast, tbl[c].l);
            end
            post();
        end

        // Four inputs streaming single-beat packets.
        do_reset();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 16; k++)
                add_pkt(i, 1, DW'(i * 256 + k));
        n = 0;
        while (log_id.size() < 64 && n < 1000) begin
            pre(1'b1); post(); n++;
        end
        chk("rr_count", log_id.size(), 64);
        for (int k = 0; k < log_id.size(); k++)
            chk($sformatf("rr_tid%0d", k), log_id[k], k % NI);

        // Back-pressure toggling during a 5-beat packet.
        do_reset();
        add_pkt(0, 5, 16'hA001);
        n = 0;
        while (log_d.size() < 5 && n < 60) begin
            pre(n % 2 == 0); post(); n++;
        end
        repeat (3) begin pre(1'b0); post(); end
        chk("bp_count", log_d.size(), 5);
        for (int k = 0; k < log_d.size(); k++)
            chk($sformatf("bp_data%0d", k), log_d[k], 16'hA001 + DW'(k));

        // Reset after beat 2 of a 4-beat packet on input 1.
        do_reset();
        add_pkt(1, 4, 16'h1001);
        n = 0;
        while (q[1].size() > 2 && n < 20) begin
            pre(1'b1); post(); n++;
        end
        chk("mr_beats_taken", q[1].size(), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_m_tvalid", m_tvalid, 0);
        chk("mr_s_tready", s_tready, 0);
        model_reset();
        add_pkt(3, 2, 16'h3001);
        add_pkt(1, 2, 16'h1101);
        add_pkt(0, 2, 16'h0001);
        n = 0;
        while (log_id.size() < 6 && n < 40) begin
            pre(1'b1); post(); n++;
        end
        chk("mr_count", log_id.size(), 6);
        if (log_id.size() == 6) begin
            chk("mr_tid0", log_id[0], 0);
            chk("mr_tid2", log_id[2], 1);
            chk("mr_tid4", log_id[4], 3);
            chk("mr_data0", log_d[0], 16'h0001);
        end

        // Randomized traffic with gaps and back-pressure.
        do_reset();
        gap = 30;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NI; i++)
                if (q[i].size() < 4 && $urandom_range(3) == 0)
                    add_pkt(i, 1 + int'($urandom_range(5)),
                            DW'(i * 4096 + c * 8));
            pre(logic'($urandom_range(1))); post();
        end
        gap = 0;
        n = 0;
        while (n < 600 && (busy || exp_out.size() != 0 || q[0].size() != 0
               || q[1].size() != 0 || q[2].size() != 0 || q[3].size() != 0)) begin
            pre(1'b1); post(); n++;
        end
        chk("rand_drained", n < 600, 1);

        // Beat limit of 4 on the second instance.
        b2 = 0; tcnt = 0; tdat = '0;
        l2_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 20; c++) begin
            s2_tvalid = (b2 < 6) ? 4'b0010 : 4'b0000;
            s2_tdata  = {32'h0, 16'hB001 + DW'(b2), 16'h0};
            s2_tlast  = {2'b00, (b2 == 5), 1'b0};
            m2_tready = 1'b1;
            #1;
            if (m2_tvalid) begin
                d2.push_back(m2_tdata);
                l2.push_back(m2_tlast);
            end
            if (trunc2) begin
                tcnt++;
                tdat = m2_tdata;
            end
            if (s2_tvalid[1] && s2_tready[1]) b2++;
            @(negedge clk);
        end
        chk("tr_count", d2.size(), 6);
        for (int k = 0; k < 6 && k < d2.size(); k++) begin
            chk($sformatf("tr_data%0d", k), d2[k], 16'hB001 + DW'(k));
            chk($sformatf("tr_last%0d", k), l2[k], l2_exp[k]);
        end
        chk("tr_pulses", tcnt, 1);
        chk("tr_pulse_beat", tdat, 16'hB004);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/axis_rr_arb.md
AXIS_RR_ARB -- requirements
Module: axis_rr_arb

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 16, the payload width per beat.
REQ-002 SHALL have parameter P_NUM_INPUTS, default 4, the number of requesting streams (2..16).
REQ-003 SHALL have parameter P_MAX_BEATS, default 256, the per-packet beat limit before forced termination.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_axis_tvalid  input  P_NUM_INPUTS  per-requester valid.
REQ-007 s_axis_tready  output  P_NUM_INPUTS  per-requester ready.
REQ-008 s_axis_tdata  input  P_NUM_INPUTS*P_DATA_WIDTH  requester i occupies bits [i*P_DATA_WIDTH +: P_DATA_WIDTH].
REQ-009 s_axis_tlast  input  P_NUM_INPUTS  per-requester end of packet.
REQ-010 m_axis_tvalid  output  1  merged stream valid.
REQ-011 m_axis_tready  input  1  downstream ready (FIFO write side).
REQ-012 m_axis_tdata  output  P_DATA_WIDTH  merged payload.
REQ-013 m_axis_tlast  output  1  merged end of packet.
REQ-014 m_axis_tid  output  clog2(P_NUM_INPUTS)  source index of current beat.
REQ-015 trunc_err  output  1  one-cycle pulse when a packet is force-terminated.

Function
REQ-016 FSM SHALL have states IDLE, GRANT; reset state IDLE.
REQ-017 IDLE: if any s_axis_tvalid set, SHALL register grant to first asserting requester searching from last_grant+1 upward, wrapping modulo P_NUM_INPUTS; next state GRANT.
REQ-018 IDLE: all s_axis_tready SHALL be 0 (one-cycle arbitration bubble per packet).
REQ-019 GRANT: only s_axis_tready[grant] SHALL be asserted, and only when the output stage can accept (empty, or m_axis_tready=1); others 0.
REQ-020 Arbitration SHALL be packet-granular: grant holds until a beat with tlast=1 is accepted from the granted requester.
REQ-021 On accepting a tlast beat, SHALL set last_grant<=grant and return to IDLE.
REQ-022 Beat counter SHALL count accepted beats of the current packet; on the P_MAX_BEATS-th beat without tlast, SHALL output that beat with m_axis_tlast=1, pulse trunc_err, return to IDLE; the requester's remaining beats form a new packet at a later grant.
REQ-023 Output stage SHALL be a registered slice: a beat accepted in cycle k appears on m_axis in cycle k+1; full throughput of one beat/cycle while m_axis_tready=1.
REQ-024 m_axis_tvalid SHALL hold with tdata/tlast/tid stable until m_axis_tready=1 (AXI-Stream rules).
REQ-025 Requester deasserting tvalid mid-packet SHALL NOT release the grant; arbiter waits.
REQ-026 Single active requester SHALL be regranted after each packet (one bubble cycle between packets).
REQ-027 last_grant reset value SHALL be P_NUM_INPUTS-1, so input 0 wins first contention.

Reset
REQ-028 On rst: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, trunc_err=0, s_axis_tready=0, beat counter=0.
REQ-029 rst mid-packet SHALL discard the held output beat and partial packet; no beat emitted after rst deasserts until a new grant.

Structure
REQ-030 Package axis_arb_pkg SHALL hold the FSM state enum and the grant-index width function.
REQ-031 Output slice SHALL be sub-module axis_reg_slice (parameterised by width, carries tdata/tlast/tid).
REQ-032 Round-robin search SHALL be a combinational function; target 120-400 RTL lines total.

Verification
REQ-033 Reset then inputs 0 and 2 each present a 3-beat packet, m_tready=1 -> output in0 beats 1..3, bubble, in2 beats 1..3; tid 0 then 2; tlast on beats 3 and 6.
REQ-034 All 4 inputs continuously send 1-beat packets -> tid sequence 0,1,2,3,0,1... with no starvation over 64 packets.
REQ-035 m_tready toggles 1/0 every cycle during a 5-beat packet 0xA001..0xA005 -> all 5 beats delivered in order, none duplicated or dropped, tdata stable while stalled.
REQ-036 P_MAX_BEATS=4, input 1 sends 6 beats with tlast on beat 6 -> beat 4 emitted with tlast=1, trunc_err pulses once; beats 5-6 emitted as a later 2-beat packet.
REQ-037 rst asserted for one cycle after beat 2 of a 4-beat packet -> m_axis_tvalid=0 next cycle, all s_axis_tready=0, state IDLE, next grant follows REQ-027.
